stream_ctrl: RTL

Parametrised N-channel stream controller that replaces the fixed two-source (fibonacci/timer) control FSM. It selects one of `NCH` data generators on a start pulse, gates its enable under buffer back-pressure, forwards its words into the CDC buffer, and stops on command or after a programmable word count. A stop drains the buffer before the block returns to idle, and a registered parity bit is kept over the buffer read-side data.

---
 rtl/stream_pkg.sv | 16 +
 rtl/prio_onehot.sv | 26 ++
 rtl/stream_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream controller: state encoding and parity helper.
package stream_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    // Zero-extension does not change an XOR-reduce, so words up to 64 bits share this helper.
    function automatic logic calc_parity(input logic [63:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/prio_onehot.sv
// Lowest-index-wins priority encoder: one-hot grant, binary index and an any-request flag.
module prio_onehot #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        // Scan from the top so the lowest set bit is the last (winning) assignment.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                gnt_o    = '0;
                gnt_o[i] = 1'b1;
                idx_o    = IW'(i);
            end
        end
        any_o = |req_i;
    end

endmodule

// File: rtl/stream_ctrl.sv
// N-channel stream controller: selects a generator on start, forwards its words into the
// CDC buffer under back-pressure, stops on command or word limit, and drains before idling.
module stream_ctrl
    import stream_pkg::*;
#(
    parameter int unsigned NCH     = 2,
    parameter int unsigned DW      = 16,
    parameter int unsigned CW      = 16,
    parameter int unsigned ODD_PAR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    start,
    input  logic              stop,
    input  logic [CW-1:0]     limit,
    input  logic [NCH-1:0]    src_valid,
    input  logic [NCH*DW-1:0] src_data,
    input  logic              buf_full,
    input  logic              buf_empty,
    input  logic              buf_out_valid,
    input  logic [DW-1:0]     buf_out_data,
    output logic [NCH-1:0]    src_en,
    output logic [NCH-1:0]    active_ch,
    output logic              push,
    output logic [DW-1:0]     push_data,
    output logic              busy,
    output logic [CW-1:0]     word_cnt,
    output logic [7:0]        drop_cnt,
    output logic              parity
);

    localparam int unsigned IW = $clog2(NCH);

    state_e            state_q, state_d;
    logic [IW-1:0]     sel_q, sel_d;
    logic [NCH-1:0]    sel_oh_q, sel_oh_d;
    logic [CW-1:0]     limit_q, limit_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              push_q, push_d;
    logic [DW-1:0]     push_data_q, push_data_d;
    logic              parity_q, parity_d;

    logic [NCH-1:0]    start_oh;
    logic [IW-1:0]     start_idx;
    logic              start_any;

    logic              cur_valid;
    logic [DW-1:0]     cur_data;
    logic              in_flow;
    logic              do_push;
    logic              do_drop;
    logic [CW:0]       cnt_next;
    logic              limit_hit;

    prio_onehot #(
        .N  (NCH),
        .IW (IW)
    ) u_start_prio (
        .req_i (start),
        .gnt_o (start_oh),
        .idx_o (start_idx),
        .any_o (start_any)
    );

    always_comb begin
        cur_valid = src_valid[sel_q];
        cur_data  = src_data[32'(sel_q) * DW +: DW];
        in_flow   = (state_q == S_RUN) || (state_q == S_WAIT);
        do_push   = in_flow && cur_valid && !buf_full;
        do_drop   = in_flow && cur_valid && buf_full;
        cnt_next  = {1'b0, word_cnt_q} + (CW + 1)'(1);
        limit_hit = (limit_q != '0) && do_push && (cnt_next == {1'b0, limit_q});
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        sel_oh_d    = sel_oh_q;
        limit_d     = limit_q;
        word_cnt_d  = word_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        push_d      = do_push;
        push_data_d = do_push ? cur_data : push_data_q;
        parity_d    = buf_out_valid ? calc_parity(64'(buf_out_data), ODD_PAR != 0) : parity_q;

        if (do_push && !(&word_cnt_q)) begin
            word_cnt_d = cnt_next[CW-1:0];
        end
        if (do_drop && !(&drop_cnt_q)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_any) begin
                    state_d    = S_RUN;
                    sel_d      = start_idx;
                    sel_oh_d   = start_oh;
                    limit_d    = limit;
                    word_cnt_d = '0;
                    drop_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (stop || limit_hit) begin
                    state_d = S_DRAIN;
                end else if (buf_full) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A word pushed on the way out of WAIT can also be the limit-reaching one.
                if (stop || limit_hit) begin
                    state_d = S_DRAIN;
                end else if (!buf_full) begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (buf_empty && !buf_out_valid) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            sel_oh_q    <= '0;
            limit_q     <= '0;
            word_cnt_q  <= '0;
            drop_cnt_q  <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            parity_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            sel_oh_q    <= sel_oh_d;
            limit_q     <= limit_d;
            word_cnt_q  <= word_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            push_q      <= push_d;
            push_data_q <= push_data_d;
            parity_q    <= parity_d;
        end
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        src_en    = (state_q == S_RUN) ? sel_oh_q : '0;
        active_ch = busy ? sel_oh_q : '0;
        push      = push_q;
        push_data = push_data_q;
        word_cnt  = word_cnt_q;
        drop_cnt  = drop_cnt_q;
        parity    = parity_q;
    end

endmodule
